// File: rtl/merge_out_packer.sv
// merge_out_packer: packs sorted P-element tuples from the merger tree into LINE_WIDTH-bit write lines.
// Optional key-order checker is built when MERGE_OUT_PACKER_ORDER_CHECK_EN is defined.
module merge_out_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int KEY_WIDTH  = 32,
  parameter int P          = 4,
  parameter int LINE_WIDTH = 512
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [P*DATA_WIDTH-1:0] i_data,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic                    i_flush,
  output logic [LINE_WIDTH-1:0]   o_line,
  output logic                    o_line_valid,
  input  logic                    i_line_ready,
  output logic                    o_line_last,
  output logic                    o_flush_done,
  output logic [31:0]             o_line_count,
  output logic                    o_order_err
);

  // state         | meaning
  // ST_FILL       | accepting tuples into the accumulator
  // ST_FLUSH_WAIT | partial line pending; waiting for the output register to free up

  localparam int TUPLE_W = P * DATA_WIDTH;
  localparam int BEATS   = LINE_WIDTH / TUPLE_W;
  localparam int SLOT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(BEATS - 1);

  typedef enum logic {ST_FILL, ST_FLUSH_WAIT} state_e;

  state_e                state_q, state_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [LINE_WIDTH-1:0] acc_q, acc_d;
  logic [LINE_WIDTH-1:0] acc_wr, line_pad;
  logic [LINE_WIDTH-1:0] line_q, line_d;
  logic                  line_valid_q, line_valid_d;
  logic                  line_last_q, line_last_d;
  logic                  flush_done_q, flush_done_d;
  logic [31:0]           line_count_q, line_count_d;

  logic out_free;
  logic handoff;
  logic accept;
  logic line_done;

  assign out_free  = ~line_valid_q | i_line_ready;
  assign handoff   = line_valid_q & i_line_ready;
  assign o_ready   = (state_q == ST_FILL) & ((slot_q != LAST_SLOT) | out_free);
  assign accept    = i_valid & o_ready;
  assign line_done = accept & (slot_q == LAST_SLOT);

  // Accumulator with the incoming tuple merged into the current slot.
  always_comb begin
    acc_wr = acc_q;
    for (int k = 0; k < BEATS; k++) begin
      if (slot_q == SLOT_W'(k)) acc_wr[k*TUPLE_W +: TUPLE_W] = i_data;
    end
  end

  // Unfilled slots become all-ones: max key, so downstream merges treat them as sentinels.
  always_comb begin
    line_pad = '1;
    for (int k = 0; k < BEATS; k++) begin
      if (SLOT_W'(k) < slot_q) line_pad[k*TUPLE_W +: TUPLE_W] = acc_q[k*TUPLE_W +: TUPLE_W];
    end
  end

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    acc_d        = acc_q;
    line_d       = line_q;
    line_valid_d = line_valid_q;
    line_last_d  = line_last_q;
    flush_done_d = 1'b0;
    line_count_d = line_count_q;

    if (handoff) begin
      line_count_d = line_count_q + 32'd1;
      line_valid_d = 1'b0;
      line_last_d  = 1'b0;
      if (line_last_q) flush_done_d = 1'b1;
    end

    case (state_q)
      ST_FILL: begin
        if (accept) begin
          acc_d  = acc_wr;
          slot_d = line_done ? '0 : slot_q + 1'b1;
        end
        if (line_done) begin
          line_d       = acc_wr;
          line_valid_d = 1'b1;
          line_last_d  = i_flush;
        end
        // A same-cycle tuple lands first; only then is the remaining fill judged.
        if (i_flush && !line_done) begin
          if (slot_d == '0) flush_done_d = 1'b1;
          else              state_d      = ST_FLUSH_WAIT;
        end
      end
      ST_FLUSH_WAIT: begin
        if (out_free) begin
          line_d       = line_pad;
          line_valid_d = 1'b1;
          line_last_d  = 1'b1;
          acc_d        = '0;
          slot_d       = '0;
          state_d      = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_FILL;
      slot_q       <= '0;
      acc_q        <= '0;
      line_q       <= '0;
      line_valid_q <= 1'b0;
      line_last_q  <= 1'b0;
      flush_done_q <= 1'b0;
      line_count_q <= '0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      acc_q        <= acc_d;
      line_q       <= line_d;
      line_valid_q <= line_valid_d;
      line_last_q  <= line_last_d;
      flush_done_q <= flush_done_d;
      line_count_q <= line_count_d;
    end
  end

  assign o_line       = line_q;
  assign o_line_valid = line_valid_q;
  assign o_line_last  = line_last_q;
  assign o_flush_done = flush_done_q;
  assign o_line_count = line_count_q;

`ifdef MERGE_OUT_PACKER_ORDER_CHECK_EN
  logic [KEY_WIDTH-1:0] last_key_q, last_key_d;
  logic                 order_err_q, order_err_d;
  logic                 order_bad;

  always_comb begin
    order_bad = 1'b0;
    if (i_data[KEY_WIDTH-1:0] < last_key_q) order_bad = 1'b1;
    for (int j = 1; j < P; j++) begin
      if (i_data[j*DATA_WIDTH +: KEY_WIDTH] < i_data[(j-1)*DATA_WIDTH +: KEY_WIDTH]) order_bad = 1'b1;
    end
    order_err_d = order_err_q | (accept & order_bad);
    // A tuple starting the next stream in the retire cycle keeps its own key.
    last_key_d = last_key_q;
    if (flush_done_d) last_key_d = '0;
    if (accept)       last_key_d = i_data[(P-1)*DATA_WIDTH +: KEY_WIDTH];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_key_q  <= '0;
      order_err_q <= 1'b0;
    end else begin
      last_key_q  <= last_key_d;
      order_err_q <= order_err_d;
    end
  end

  assign o_order_err = order_err_q;
`else
  assign o_order_err = 1'b0;
`endif

endmodule

// File: tb/tb_merge_out_packer.sv
// Directed self-checking bench for merge_out_packer: fill, stall, flush variants, reset, order check.
module tb_merge_out_packer;
  localparam int DW = 32;
  localparam int P  = 4;
  localparam int LW = 512;
  localparam int TW = P * DW;

`ifdef MERGE_OUT_PACKER_ORDER_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [TW-1:0] i_data;
  logic          i_valid;
  logic          o_ready;
  logic          i_flush;
  logic [LW-1:0] o_line;
  logic          o_line_valid;
  logic          i_line_ready;
  logic          o_line_last;
  logic          o_flush_done;
  logic [31:0]   o_line_count;
  logic          o_order_err;

  int n_tests = 0;
  int n_fail  = 0;

  merge_out_packer dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_data       (i_data),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_flush      (i_flush),
    .o_line       (o_line),
    .o_line_valid (o_line_valid),
    .i_line_ready (i_line_ready),
    .o_line_last  (o_line_last),
    .o_flush_done (o_flush_done),
    .o_line_count (o_line_count),
    .o_order_err  (o_order_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [TW-1:0] mk_tuple(input int base);
    logic [TW-1:0] t;
    for (int j = 0; j < P; j++) t[j*DW +: DW] = DW'(base + j);
    return t;
  endfunction

  // Line of 16 consecutive elements starting at base.
  function automatic logic [LW-1:0] mk_line(input int base);
    logic [LW-1:0] l;
    for (int e = 0; e < LW/DW; e++) l[e*DW +: DW] = DW'(base + e);
    return l;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LW-1:0] exp_line;
    logic [TW-1:0] t;
    logic          rdy;
    int            acc_cnt;

    rst_n = 1'b0; i_data = '0; i_valid = 1'b0; i_flush = 1'b0; i_line_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_valid", o_line_valid, 0);
    check("rst_last", o_line_last, 0);
    check("rst_line", o_line, 0);
    check("rst_count", o_line_count, 0);
    check("rst_flush_done", o_flush_done, 0);
    check("rst_order_err", o_order_err, 0);
    check("rst_ready", o_ready, 1);
    tick();

    // fill one line with elements 1..16
    i_line_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_valid = 1'b1; i_data = mk_tuple(1 + 4*k);
      @(negedge clk);
      check("fill_ready", o_ready, 1);
      tick();
    end
    i_valid = 1'b0; i_data = '0;
    @(negedge clk);
    check("fill_valid", o_line_valid, 1);
    check("fill_lo", o_line[31:0], 1);
    check("fill_hi", o_line[511:480], 16);
    check("fill_line", o_line, mk_line(1));
    check("fill_last", o_line_last, 0);
    check("fill_count_pre", o_line_count, 0);
    tick();
    @(negedge clk);
    check("fill_count", o_line_count, 1);
    check("fill_cleared", o_line_valid, 0);
    tick();

    // stall: write channel blocked, stream 12 tuples
    i_line_ready = 1'b0;
    acc_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      i_valid = 1'b1; i_data = mk_tuple(256 + 4*acc_cnt);
      @(negedge clk);
      rdy = o_ready;
      tick();
      if (rdy) acc_cnt++;
    end
    check("stall_accepted", acc_cnt, 7);
    @(negedge clk);
    check("stall_ready", o_ready, 0);
    check("stall_held_valid", o_line_valid, 1);
    check("stall_held_line", o_line, mk_line(256));
    check("stall_count", o_line_count, 1);
    tick();
    i_line_ready = 1'b1;
    @(negedge clk);
    check("release_ready", o_ready, 1);
    tick();
    @(negedge clk);
    check("release_count", o_line_count, 2);
    check("release_valid", o_line_valid, 1);
    check("release_line", o_line, mk_line(272));
    for (int k = 8; k < 12; k++) begin
      i_data = mk_tuple(256 + 4*k);
      tick();
    end
    i_valid = 1'b0; i_data = '0;
    @(negedge clk);
    check("b2b_line", o_line, mk_line(288));
    check("b2b_count", o_line_count, 3);
    tick();
    @(negedge clk);
    check("b2b_count_post", o_line_count, 4);
    check("b2b_cleared", o_line_valid, 0);

    // partial flush: two tuples then flush
    for (int k = 0; k < 2; k++) begin
      i_valid = 1'b1; i_data = mk_tuple(1 + 4*k);
      tick();
    end
    i_valid = 1'b0; i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    @(negedge clk);
    check("pflush_wait_ready", o_ready, 0);
    check("pflush_wait_valid", o_line_valid, 0);
    tick();
    exp_line = '1;
    for (int e = 0; e < 8; e++) exp_line[e*DW +: DW] = DW'(e + 1);
    @(negedge clk);
    check("pflush_valid", o_line_valid, 1);
    check("pflush_last", o_line_last, 1);
    check("pflush_line", o_line, exp_line);
    check("pflush_done_early", o_flush_done, 0);
    tick();
    @(negedge clk);
    check("pflush_done", o_flush_done, 1);
    check("pflush_cleared", o_line_valid, 0);
    check("pflush_count", o_line_count, 5);
    tick();
    @(negedge clk);
    check("pflush_done_pulse", o_flush_done, 0);

    // empty flush at slot 0
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    @(negedge clk);
    check("eflush_done", o_flush_done, 1);
    check("eflush_no_line", o_line_valid, 0);
    tick();
    @(negedge clk);
    check("eflush_done_pulse", o_flush_done, 0);
    check("eflush_count", o_line_count, 5);

    // exact flush with the 4th tuple
    for (int k = 0; k < 4; k++) begin
      i_valid = 1'b1; i_data = mk_tuple(64 + 4*k);
      i_flush = (k == 3);
      tick();
    end
    i_valid = 1'b0; i_flush = 1'b0;
    @(negedge clk);
    check("xflush_valid", o_line_valid, 1);
    check("xflush_last", o_line_last, 1);
    check("xflush_line", o_line, mk_line(64));
    check("xflush_done_early", o_flush_done, 0);
    tick();
    @(negedge clk);
    check("xflush_done", o_flush_done, 1);
    check("xflush_count", o_line_count, 6);
    check("xflush_cleared", o_line_valid, 0);
    tick();
    @(negedge clk);
    check("xflush_no_pad_line", o_line_valid, 0);
    check("xflush_done_pulse", o_flush_done, 0);

    // reset mid-line
    for (int k = 0; k < 3; k++) begin
      i_valid = 1'b1; i_data = mk_tuple(1280 + 4*k);
      tick();
    end
    i_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_valid", o_line_valid, 0);
    check("mrst_line", o_line, 0);
    check("mrst_count", o_line_count, 0);
    for (int k = 0; k < 4; k++) begin
      i_valid = 1'b1; i_data = mk_tuple(1536 + 4*k);
      tick();
    end
    i_valid = 1'b0;
    @(negedge clk);
    check("mrst_new_valid", o_line_valid, 1);
    check("mrst_new_line", o_line, mk_line(1536));
    tick();
    @(negedge clk);
    check("mrst_new_count", o_line_count, 1);

    // order check
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    i_valid = 1'b1; i_data = mk_tuple(5);
    tick();
    i_valid = 1'b0;
    @(negedge clk);
    check("order_ok", o_order_err, 0);
    t = '0;
    t[0*DW +: DW] = 32'd4;
    t[1*DW +: DW] = 32'd9;
    t[2*DW +: DW] = 32'd10;
    t[3*DW +: DW] = 32'd11;
    i_valid = 1'b1; i_data = t;
    tick();
    i_valid = 1'b0;
    @(negedge clk);
    check("order_err", o_order_err, EXP_ERR);
    i_valid = 1'b1; i_data = mk_tuple(20);
    tick();
    i_valid = 1'b0;
    tick();
    @(negedge clk);
    check("order_sticky", o_order_err, EXP_ERR);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/merge_out_packer.md
Name: merge_out_packer

Overview:
- Sits directly downstream of the P=4 merger tree, in place of the test-bench output FIFO.
- Accepts one P-element sorted tuple per cycle (P*DATA_WIDTH bits) through a valid/ready handshake.
- Packs tuples into LINE_WIDTH-bit lines for the memory write path.
- Double-buffered: the accumulator keeps filling while a completed line waits for the write channel. A flush command pads and emits a trailing partial line.

Parameters:
- DATA_WIDTH, 32, element width in bits.
- KEY_WIDTH, 32, key field width; key = element bits [KEY_WIDTH-1:0].
- P, 4, elements per input tuple.
- LINE_WIDTH, 512, output line width; must be a multiple of P*DATA_WIDTH.
- BEATS, LINE_WIDTH/(P*DATA_WIDTH) = 4, derived; tuples per line.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_data  in  P*DATA_WIDTH  tuple from the merger tree; element j at bits [j*DATA_WIDTH +: DATA_WIDTH]; j=0 is earliest in sort order.
- i_valid  in  1  tuple present; driven by the tree's o_out_fifo_write.
- o_ready  out  1  packer can accept; drives the tree's i_fifo_out_ready.
- i_flush  in  1  single-cycle pulse: end of stream, emit any partial line.
- o_line  out  LINE_WIDTH  completed line; tuple k at bits [k*P*DATA_WIDTH +: P*DATA_WIDTH].
- o_line_valid  out  1  o_line holds a line.
- i_line_ready  in  1  write channel consumes o_line this cycle.
- o_line_last  out  1  qualifies o_line_valid; final line of a flushed stream.
- o_flush_done  out  1  one-cycle pulse when the flush is fully retired.
- o_line_count  out  32  lines handed off (o_line_valid & i_line_ready); wraps at 2^32.
- o_order_err  out  1  sticky ordering error; see Optional Feature.

Behaviour:
- Reset (async assert, sync release): slot=0, accumulator=0, o_line=0, o_line_valid=0, o_line_last=0, o_flush_done=0, o_line_count=0, o_order_err=0, state=FILL.
- Accept = i_valid & o_ready. The accepted tuple is written to accumulator slot `slot`, and slot increments modulo BEATS.
- o_ready is combinational:
  - In FILL: 1 when slot<BEATS-1, or when slot==BEATS-1 & (~o_line_valid | i_line_ready).
  - In FLUSH_WAIT: 0.
- Line completion: accepting at slot==BEATS-1 copies the full accumulator into o_line, and o_line_valid=1 on the next edge. Latency from the last tuple accept to o_line_valid is 1 cycle.
- Back-to-back: with i_line_ready held 1, sustained throughput is one tuple per cycle with no bubbles.
- o_line, o_line_valid and o_line_last are held stable while o_line_valid & ~i_line_ready.
- Handoff with no new line loaded: o_line_valid clears on the next edge.
- o_line_count increments on every handoff.
- Flush, sampled in FILL:
  - A tuple accepted in the same cycle is placed first.
  - If the resulting slot count is 0 and that tuple completed a line, that line gets o_line_last=1.
  - If the resulting slot count is 0 with no line just completed, pulse o_flush_done next cycle and emit no line.
  - Otherwise (partial line), go to FLUSH_WAIT.
- FLUSH_WAIT:
  - Unfilled slots are padded with all-ones elements, the max key, which acts as a sort sentinel.
  - When the output register is free (~o_line_valid | i_line_ready), load the padded line with o_line_last=1, clear the accumulator, set slot=0 and return to FILL.
- o_flush_done pulses on the edge after the o_line_last line is handed off.
- i_flush while in FLUSH_WAIT is ignored. i_valid in FLUSH_WAIT is not accepted because o_ready=0.
- Reset asserted mid-line discards the partial accumulator and any held line with no output, and returns to reset values.

Optional Feature:
- Macro: MERGE_OUT_PACKER_ORDER_CHECK_EN.
- Defined:
  - On each accept, check key(e0) >= last_key and key(e_j) >= key(e_{j-1}) for j=1..P-1, unsigned compare.
  - Any violation sets o_order_err=1 until reset.
  - last_key is updated to key(e_{P-1}); it resets to 0 and also clears on flush completion.
  - Padding elements are not checked.
- Undefined: o_order_err is tied to 0 and there is no comparator logic.

Test Plan:
- Fill: 4 tuples 0x..01..0x..10 (elements 1..16), i_line_ready=1 → o_line_valid 1 cycle after 4th accept, o_line[31:0]=1, o_line[511:480]=16, o_line_count=1.
- Stall: 12 tuples streamed with i_line_ready=0 → first line held. o_ready drops on the 8th tuple (slot 3 with output full), i.e. 7 accepted. Raising i_line_ready → 8th accepted that cycle, count increments.
- Partial flush: 2 tuples (elements 1..8) then i_flush → line with elements 1..8 in bits [255:0], bits [511:256] all 0xFFFFFFFF, o_line_last=1, o_flush_done pulse next cycle after handoff.
- Empty flush / exact flush: i_flush at slot 0 → no line, o_flush_done next cycle. i_flush together with the 4th tuple → one line with o_line_last=1 and no padded line.
- Reset mid-line: 3 tuples accepted then i_rst_n low for 1 cycle → no line emitted; after release, 4 fresh tuples produce a line containing only the new data, o_line_count=1.
- Order check (macro defined): tuple keys {5,6,7,8} then {4,9,10,11} → o_order_err=1 and sticky. Same stimulus without the macro → o_order_err stays 0.
